ncl_ring_ctrl: RTL and testbench

Clocked sequencer and monitor for a free-running NCL dual-rail oscillation ring.
- Drives the ring's init line and releases the ring after a programmed hold.
- Samples one dual-rail stage tap and counts DATA wavefronts over a fixed window, giving a frequency figure.
- Detects stalled or illegal ring states.
- Sits at the boundary between the clockless ring under test and the clocked bench/readout logic.

---
 rtl/ncl_ring_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ncl_ring_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ncl_ring_ctrl.sv
// Sequencer and wavefront monitor for a free-running NCL dual-rail oscillation ring.
// Optional auto-restart on stall is enabled by defining NCL_RING_AUTORESTART_EN.
module ncl_ring_ctrl #(
  parameter int unsigned INIT_CYC    = 4,
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned WINDOW      = 256,
  parameter int unsigned STALL_CYC   = 64,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MAX_RESTART = 3
) (
  input  logic             clk,
  input  logic             init,
  input  logic             start,
  input  logic [1:0]       tap,
  output logic             ring_init,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] wave_count,
  output logic             stall,
  output logic             illegal,
  output logic [1:0]       restarts
);

  localparam int unsigned MAX_A  = (INIT_CYC > SETTLE_CYC) ? INIT_CYC : SETTLE_CYC;
  localparam int unsigned MAX_PH = (MAX_A > WINDOW) ? MAX_A : WINDOW;
  localparam int unsigned CYC_W  = $clog2(MAX_PH + 1);
  localparam int unsigned STL_W  = $clog2(STALL_CYC + 1);

  // restarts is a 2-bit output, so the limit cannot exceed 3.
  if (MAX_RESTART > 3) begin : g_bad_max_restart
    $error("MAX_RESTART must not exceed 3");
  end

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StSettle,
    StMeasure,
    StStall
  } state_e;

  state_e             r_state, w_state_d;
  logic [1:0]         r_s1, r_s2, r_p;
  logic [CYC_W-1:0]   r_cyc;
  logic [STL_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_wave_count;
  logic               r_done, r_stall, r_illegal;
  logic [1:0]         r_restarts;

  logic w_watch, w_wave, w_change, w_stall_hit;
  logic w_begin, w_cyc_end, w_restart, w_to_stall, w_done_d;

  assign w_watch     = (r_state == StSettle) || (r_state == StMeasure);
  assign w_wave      = (r_p == 2'b00) && ((r_s2 == 2'b01) || (r_s2 == 2'b10));
  assign w_change    = (r_s2 != r_p);
  assign w_stall_hit = w_watch && !w_change && (r_stall_cnt == STL_W'(STALL_CYC - 1));

  always_comb begin
    w_state_d  = r_state;
    w_begin    = 1'b0;
    w_cyc_end  = 1'b0;
    w_restart  = 1'b0;
    w_to_stall = 1'b0;
    w_done_d   = 1'b0;
    unique case (r_state)
      StIdle, StStall: begin
        if (start) begin
          w_state_d = StInit;
          w_begin   = 1'b1;
        end
      end
      StInit: begin
        if (r_cyc == CYC_W'(INIT_CYC - 1)) begin
          w_state_d = StSettle;
          w_cyc_end = 1'b1;
        end
      end
      StSettle, StMeasure: begin
        // A window ending on the stall-threshold cycle still counts as a good window.
        if ((r_state == StMeasure) && (r_cyc == CYC_W'(WINDOW - 1))) begin
          w_state_d = StIdle;
          w_cyc_end = 1'b1;
          w_done_d  = 1'b1;
        end else if (w_stall_hit) begin
`ifdef NCL_RING_AUTORESTART_EN
          if (32'(r_restarts) < MAX_RESTART) begin
            w_state_d = StInit;
            w_restart = 1'b1;
          end else begin
            w_state_d  = StStall;
            w_to_stall = 1'b1;
          end
`else
          w_state_d  = StStall;
          w_to_stall = 1'b1;
`endif
        end else if ((r_state == StSettle) && (r_cyc == CYC_W'(SETTLE_CYC - 1))) begin
          w_state_d = StMeasure;
          w_cyc_end = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      r_state      <= StIdle;
      r_s1         <= 2'b00;
      r_s2         <= 2'b00;
      r_p          <= 2'b00;
      r_cyc        <= '0;
      r_stall_cnt  <= '0;
      r_wave_count <= '0;
      r_done       <= 1'b0;
      r_stall      <= 1'b0;
      r_illegal    <= 1'b0;
      r_restarts   <= 2'b00;
    end else begin
      r_s1    <= tap;
      r_s2    <= r_s1;
      r_p     <= r_s2;
      r_state <= w_state_d;
      r_done  <= w_done_d;

      if (w_begin || w_cyc_end || w_restart) begin
        r_cyc <= '0;
      end else if (busy) begin
        r_cyc <= r_cyc + 1'b1;
      end

      if (!w_watch || w_change) begin
        r_stall_cnt <= '0;
      end else if (r_stall_cnt != STL_W'(STALL_CYC)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end

      if (w_begin || w_restart) begin
        r_wave_count <= '0;
      end else if ((r_state == StMeasure) && w_wave && (r_wave_count != '1)) begin
        r_wave_count <= r_wave_count + 1'b1;
      end

      if (w_begin) begin
        r_stall <= 1'b0;
      end else if (w_to_stall) begin
        r_stall <= 1'b1;
      end

      if (w_begin) begin
        r_illegal <= 1'b0;
      end else if (w_watch && (r_s2 == 2'b11)) begin
        r_illegal <= 1'b1;
      end

      if (w_begin) begin
        r_restarts <= 2'b00;
      end else if (w_restart) begin
        r_restarts <= r_restarts + 2'd1;
      end
    end
  end

  assign ring_init  = !w_watch;
  assign busy       = (r_state == StInit) || w_watch;
  assign done       = r_done;
  assign wave_count = r_wave_count;
  assign stall      = r_stall;
  assign illegal    = r_illegal;
  assign restarts   = r_restarts;

endmodule

// File: tb/tb_ncl_ring_ctrl.sv
// Directed bench for ncl_ring_ctrl: default instance plus a CNT_W=4 instance sharing stimulus.
module tb_ncl_ring_ctrl;

  logic        clk = 1'b0;
  logic        init, start;
  logic [1:0]  tap;
  logic        ring_init, busy, done, stall, illegal;
  logic [15:0] wave_count;
  logic [1:0]  restarts;
  logic        s_ring_init, s_busy, s_done, s_stall, s_illegal;
  logic [3:0]  s_wave_count;
  logic [1:0]  s_restarts;

  int total = 0;
  int bad   = 0;
  int k     = 0;
  int mode  = 0;
  int done_cnt = 0;
  int snap;

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  ncl_ring_ctrl u_dut (
    .clk       (clk),
    .init      (init),
    .start     (start),
    .tap       (tap),
    .ring_init (ring_init),
    .busy      (busy),
    .done      (done),
    .wave_count(wave_count),
    .stall     (stall),
    .illegal   (illegal),
    .restarts  (restarts)
  );

  ncl_ring_ctrl #(.CNT_W(4)) u_sat (
    .clk       (clk),
    .init      (init),
    .start     (start),
    .tap       (tap),
    .ring_init (s_ring_init),
    .busy      (s_busy),
    .done      (s_done),
    .wave_count(s_wave_count),
    .stall     (s_stall),
    .illegal   (s_illegal),
    .restarts  (s_restarts)
  );

  // Tap value driven during cycle kk after the start edge, for each stimulus mode.
  function automatic logic [1:0] pat(input int m, input int kk);
    case (m)
      1:       return kk[2] ? 2'b01 : 2'b00;
      2:       return kk[1] ? 2'b01 : 2'b00;
      3:       return (kk >= 129 && kk <= 131) ? 2'b11 : (kk[2] ? 2'b01 : 2'b00);
      4:       return (kk >= 5) ? 2'b10 : 2'b00;
      default: return 2'b00;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    tap = pat(mode, k);
  endtask

  task automatic go_to(input int target);
    while (k < target) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    k     = 0;
    tap   = pat(mode, 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    init  = 1'b1;
    start = 1'b1;
    tap   = 2'b00;
    tick();
    tick();
    init  = 1'b0;
    start = 1'b0;
    chk("rst_ring_init", 32'(ring_init), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wave", 32'(wave_count), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_restarts", 32'(restarts), 0);
    tick();
    chk("start_with_init_ignored", 32'(busy), 0);

    // Normal window, toggle every 4 cycles; a start mid-window is ignored.
    mode = 1;
    pulse_start();
    go_to(3);
    chk("init_hold_ring_init", 32'(ring_init), 1);
    chk("init_busy", 32'(busy), 1);
    go_to(4);
    chk("release_ring_init", 32'(ring_init), 0);
    go_to(100);
    start = 1'b1;
    tick();
    start = 1'b0;
    go_to(267);
    chk("pre_done", 32'(done), 0);
    chk("pre_done_busy", 32'(busy), 1);
    go_to(268);
    chk("done_pulse", 32'(done), 1);
    chk("wave_32", 32'(wave_count), 32);
    chk("sat_wave_15a", 32'(s_wave_count), 15);
    chk("done_busy", 32'(busy), 0);
    chk("done_ring_init", 32'(ring_init), 1);
    chk("done_no_stall", 32'(stall), 0);
    go_to(269);
    chk("done_one_cycle", 32'(done), 0);
    chk("wave_hold", 32'(wave_count), 32);

    // Faster toggle; default counts 64, narrow counter saturates.
    mode = 2;
    pulse_start();
    chk("wave_cleared", 32'(wave_count), 0);
    go_to(268);
    chk("done_fast", 32'(done), 1);
    chk("wave_64", 32'(wave_count), 64);
    chk("sat_wave_15b", 32'(s_wave_count), 15);

    // Reset mid-measurement aborts at once.
    mode = 1;
    pulse_start();
    go_to(150);
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ring_init", 32'(ring_init), 1);
    chk("abort_wave", 32'(wave_count), 0);
    mode = 0;
    repeat (5) tick();

    // Illegal 11 pulse mid-window swallows one wavefront and is not itself counted.
    mode = 3;
    pulse_start();
    go_to(100);
    chk("illegal_clear", 32'(illegal), 0);
    go_to(268);
    chk("illegal_set", 32'(illegal), 1);
    chk("illegal_done", 32'(done), 1);
    chk("illegal_wave_31", 32'(wave_count), 31);
    mode = 0;
    repeat (5) tick();

    // Tap frozen at DATA1 from cycle 5; last synced change lands at cycle 8.
    mode = 4;
    snap = done_cnt;
    pulse_start();
    chk("start_clears_illegal", 32'(illegal), 0);
    go_to(71);
    chk("pre_stall", 32'(stall), 0);
    chk("pre_stall_busy", 32'(busy), 1);
`ifdef NCL_RING_AUTORESTART_EN
    go_to(72);
    chk("restart1", 32'(restarts), 1);
    chk("restart1_busy", 32'(busy), 1);
    chk("restart1_ring_init", 32'(ring_init), 1);
    chk("restart1_no_stall", 32'(stall), 0);
    go_to(139);
    chk("restart1_hold", 32'(restarts), 1);
    go_to(140);
    chk("restart2", 32'(restarts), 2);
    go_to(208);
    chk("restart3", 32'(restarts), 3);
    go_to(275);
    chk("pre_final_stall", 32'(stall), 0);
    go_to(276);
    chk("final_stall", 32'(stall), 1);
    chk("final_busy", 32'(busy), 0);
    chk("final_restarts", 32'(restarts), 3);
    chk("final_ring_init", 32'(ring_init), 1);
`else
    go_to(72);
    chk("stall_set", 32'(stall), 1);
    chk("stall_ring_init", 32'(ring_init), 1);
    chk("stall_busy", 32'(busy), 0);
    chk("stall_wave", 32'(wave_count), 0);
    chk("stall_restarts", 32'(restarts), 0);
`endif
    go_to(400);
    chk("stall_no_done", done_cnt - snap, 0);
    chk("stall_sticky", 32'(stall), 1);
    mode = 1;
    pulse_start();
    chk("restart_clears_stall", 32'(stall), 0);
    chk("restart_clears_restarts", 32'(restarts), 0);
    chk("restart_busy", 32'(busy), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
